// File: rtl/pll_reset_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: sequencer states,
// default timing constants and a small sizing helper.
package ngv_clk_pkg;

    typedef enum logic [2:0] {
        PLLRST = 3'd0,
        SETTLE = 3'd1,
        CHECK  = 3'd2,
        RUN    = 3'd3,
        FAIL   = 3'd4
    } pll_state_e;

    localparam int DEF_RST_CYCLES    = 64;
    localparam int DEF_SETTLE_CYCLES = 4200;
    localparam int DEF_HB_TIMEOUT    = 256;
    localparam int DEF_HB_EDGES      = 4;
    localparam int DEF_MAX_RETRY     = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_reset_seq_hb_sync.sv
// Brings the clk0_out-domain heartbeat into refclk and flags every toggle.
// hb_edge is high for one refclk cycle per hb_in transition.
module hb_sync (
    input  logic refclk,
    input  logic reset,
    input  logic hb_in,
    output logic hb_edge
);

    // [0] and [1] form the synchronizer, [2] is the delay flop for edge detection
    logic [2:0] sync_q;

    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], hb_in};
        end
    end

    assign hb_edge = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: holds the PLL in reset, waits for lock settle, checks the
// heartbeat, then releases system reset; heartbeat loss retries a bounded number of times.
module pll_reset_seq
    import ngv_clk_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int HB_TIMEOUT    = DEF_HB_TIMEOUT,
    parameter int HB_EDGES      = DEF_HB_EDGES,
    parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic       refclk,
    input  logic       reset,
    input  logic       hb_in,
    output logic       pll_reset,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [1:0] retry_cnt,
    output logic [2:0] state_dbg
);

    localparam int CNT_MAX = max3(RST_CYCLES, SETTLE_CYCLES, HB_TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int EDGE_W  = $clog2(HB_EDGES + 1);

    localparam logic [CNT_W-1:0]  CNT_SAT     = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0]  RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HB_LIMIT    = CNT_W'(HB_TIMEOUT);
    localparam logic [EDGE_W-1:0] EDGE_SAT    = EDGE_W'(HB_EDGES);
    localparam logic [1:0]        RETRY_MAX   = 2'(MAX_RETRY);

    pll_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [EDGE_W-1:0] edge_q, edge_d, edge_inc;
    logic [1:0]        retry_q, retry_d;
    logic              hb_edge;
    logic              take_retry;

    hb_sync u_hb_sync (
        .refclk  (refclk),
        .reset   (reset),
        .hb_in   (hb_in),
        .hb_edge (hb_edge)
    );

    assign cnt_inc  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    assign edge_inc = (edge_q == EDGE_SAT) ? edge_q : edge_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        edge_d     = edge_q;
        retry_d    = retry_q;
        take_retry = 1'b0;
        case (state_q)
            PLLRST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                    edge_d  = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            // An edge in the same cycle the timeout is reached still wins.
            CHECK: begin
                if (hb_edge) begin
                    cnt_d  = '0;
                    edge_d = edge_inc;
                    if (edge_inc == EDGE_SAT) begin
                        state_d = RUN;
                    end
                end else if (cnt_q == HB_LIMIT) begin
                    take_retry = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RUN: begin
                if (hb_edge) begin
                    cnt_d = '0;
                end else if (cnt_q == HB_LIMIT) begin
                    take_retry = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = PLLRST;
                cnt_d   = '0;
                edge_d  = '0;
            end
        endcase

        if (take_retry) begin
            cnt_d  = '0;
            edge_d = '0;
            if (retry_q == RETRY_MAX) begin
                state_d = FAIL;
            end else begin
                retry_d = retry_q + 2'd1;
                state_d = PLLRST;
            end
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            state_q   <= PLLRST;
            cnt_q     <= '0;
            edge_q    <= '0;
            retry_q   <= 2'd0;
            pll_reset <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            retry_q   <= retry_d;
            pll_reset <= (state_d == PLLRST) || (state_d == FAIL);
            sys_rst   <= (state_d != RUN);
            ready     <= (state_d == RUN);
            fail      <= (state_d == FAIL);
        end
    end

    assign retry_cnt = retry_q;
    assign state_dbg = state_q;

endmodule
